iter_mul_div: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO result registers; sequential successor to the combinational utility arithmetic blocks.

---
 rtl/iter_mul_div.sv | 189 ++++++++++++++++++
 tb/tb_iter_mul_div.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_mul_div.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Iterates one quotient/product bit per cycle on operand magnitudes, then fixes up signs.
module iter_mul_div #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [Width-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int CntW = $clog2(Width) + 1;
  localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [Width-1:0]    hi_q, hi_d;
  logic [Width-1:0]    lo_q, lo_d;

  logic [1:0]          op_q, op_d;
  logic [Width-1:0]    a_q, a_d;
  logic [Width-1:0]    b_q, b_d;
  logic [2*Width-1:0]  acc_q, acc_d;
  logic [Width-1:0]    m_q, m_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic                ovf_q, ovf_d;

  logic                accept;
  logic                is_signed;
  logic [2*Width-1:0]  res;

  function automatic logic [Width-1:0] mag(input logic signed [Width-1:0] v,
                                           input logic is_sgn);
    logic signed [Width-1:0] n;
    n = -v;
    return (is_sgn && v < 0) ? $unsigned(n) : $unsigned(v);
  endfunction

  // acc = {partial product upper half, remaining multiplier bits}; shift right each step.
  function automatic logic [2*Width-1:0] mul_step(input logic [2*Width-1:0] acc,
                                                  input logic [Width-1:0] m);
    logic [Width:0] sum;
    sum = {1'b0, acc[2*Width-1:Width]} + (acc[0] ? {1'b0, m} : {(Width+1){1'b0}});
    return {sum, acc[Width-1:1]};
  endfunction

  // acc = {remainder, dividend/quotient}; restoring shift-subtract.
  function automatic logic [2*Width-1:0] div_step(input logic [2*Width-1:0] acc,
                                                  input logic [Width-1:0] m);
    logic [Width:0] diff;
    diff = acc[2*Width-1:Width-1] - {1'b0, m};
    if (!diff[Width]) return {diff[Width-1:0], acc[Width-2:0], 1'b1};
    return {acc[2*Width-2:0], 1'b0};
  endfunction

  function automatic logic [2*Width-1:0] fixup(input logic is_div,
                                               input logic neg_res,
                                               input logic neg_rem,
                                               input logic dz,
                                               input logic ovf,
                                               input logic [2*Width-1:0] acc,
                                               input logic [Width-1:0] dividend);
    logic [Width-1:0] quo;
    logic [Width-1:0] rem;
    quo = acc[Width-1:0];
    rem = acc[2*Width-1:Width];
    if (!is_div) return neg_res ? -acc : acc;
    if (dz) return {dividend, {Width{1'b1}}};
    if (ovf) return {{Width{1'b0}}, MinVal};
    return {(neg_rem ? -rem : rem), (neg_res ? -quo : quo)};
  endfunction

  assign busy_o    = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIXUP);
  assign done_o    = (state_q == S_DONE);
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign accept    = start_i && !flush_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign is_signed = !op_q[0];
  assign res       = fixup(op_q[1], neg_res_q, neg_rem_q, dz_q, ovf_q, acc_q, a_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    m_d       = m_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_PREP;
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        neg_res_d = is_signed && (a_q[Width-1] ^ b_q[Width-1]);
        neg_rem_d = is_signed && a_q[Width-1];
        dz_d      = (b_q == '0);
        ovf_d     = is_signed && op_q[1] && (a_q == MinVal) && (b_q == '1);
        acc_d     = {{Width{1'b0}}, mag(a_q, is_signed)};
        m_d       = mag(b_q, is_signed);
        cnt_d     = '0;
        state_d   = S_CALC;
      end
      S_CALC: begin
        acc_d = op_q[1] ? div_step(acc_q, m_q) : mul_step(acc_q, m_q);
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(Width - 1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        {hi_d, lo_d} = res;
        state_d      = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush discards the in-flight result, including one about to be committed.
    if (flush_i) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    if (!busy_o && !accept) begin
      if (hi_we_i) hi_d = wdata_i;
      if (lo_we_i) lo_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Working datapath registers are only meaningful after PREP, so they carry no reset.
  always_ff @(posedge clk_i) begin
    op_q      <= op_d;
    a_q       <= a_d;
    b_q       <= b_d;
    acc_q     <= acc_d;
    m_q       <= m_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    dz_q      <= dz_d;
    ovf_q     <= ovf_d;
  end

endmodule

// File: tb/tb_iter_mul_div.sv
// Scoreboard bench for iter_mul_div: expected HI/LO queued at accept, checked on done_o.
module tb_iter_mul_div;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   op_i = '0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         flush_i = 1'b0;
  logic         hi_we_i = 1'b0;
  logic         lo_we_i = 1'b0;
  logic [W-1:0] wdata_i = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  iter_mul_div #(.Width(W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           t0;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] sh_hi = '0;
  logic [W-1:0] sh_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic signed [63:0] sp;
    logic signed [W-1:0] sa, sbv, q, r;
    sa = a;
    sbv = b;
    case (op)
      2'b00: begin
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        return sp;
      end
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_ni && done_o) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_hi", hi_o, e.hi);
        chk("sb_lo", lo_o, e.lo);
        chk("done_latency", cyc - e.t0 + 1, W + 3);
        sh_hi = e.hi;
        sh_lo = e.lo;
      end
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit track);
    exp_t e;
    op_i = op;
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (track) begin
      {e.hi, e.lo} = model(op, a, b);
      e.t0 = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(output int nbusy);
    int n;
    n = 0;
    nbusy = 0;
    forever begin
      @(negedge clk);
      if (busy_o) nbusy++;
      if (done_o) break;
      n++;
      if (n > 100) begin
        chk("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int nb;
  logic [1:0] rop;
  logic [W-1:0] ra, rb;

  initial begin
    idle_cycles(3);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    rst_ni = 1'b1;
    idle_cycles(2);

    // Directed vectors, each started in the DONE cycle of the previous one.
    start_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1);
    wait_done(nb);
    chk("mult_busy_cycles", nb, W + 2);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFF1);
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_done(nb);
    chk("multu_hi", hi_o, 32'hFFFF_FFFE);
    chk("multu_lo", lo_o, 32'h0000_0001);
    start_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1);
    wait_done(nb);
    chk("div_hi", hi_o, 32'hFFFF_FFFF);
    chk("div_lo", lo_o, 32'hFFFF_FFFD);
    start_op(2'b11, 32'd7, 32'd0, 1);
    wait_done(nb);
    chk("divu0_hi", hi_o, 32'h0000_0007);
    chk("divu0_lo", lo_o, 32'hFFFF_FFFF);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done(nb);
    chk("divovf_hi", hi_o, 32'h0000_0000);
    chk("divovf_lo", lo_o, 32'h8000_0000);
    start_op(2'b11, 32'd100, 32'd7, 1);
    wait_done(nb);
    chk("divu_b2b_hi", hi_o, 32'h0000_0002);
    chk("divu_b2b_lo", lo_o, 32'h0000_000E);
    idle_cycles(3);

    // A start while busy must not disturb the latched operands.
    start_op(2'b01, 32'd1000, 32'd3, 1);
    idle_cycles(4);
    op_i = 2'b00; a_i = 32'd5; b_i = 32'd5; start_i = 1'b1;
    idle_cycles(1);
    start_i = 1'b0;
    wait_done(nb);
    chk("ignored_start_lo", lo_o, 32'd3000);
    idle_cycles(2);

    // Flush mid-operation: no done, HI/LO keep the prior result.
    start_op(2'b11, 32'd50, 32'd6, 0);
    idle_cycles(4);
    op_i = 2'b00; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1;
    idle_cycles(1);
    start_i = 1'b0;
    idle_cycles(4);
    flush_i = 1'b1;
    idle_cycles(1);
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    repeat (45) @(negedge clk);
    chk("flush_hi", hi_o, sh_hi);
    chk("flush_lo", lo_o, sh_lo);
    idle_cycles(1);

    // MTHI/MTLO while busy are dropped.
    start_op(2'b01, 32'd2, 32'd3, 0);
    idle_cycles(3);
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h1234_5678;
    idle_cycles(1);
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    flush_i = 1'b1;
    idle_cycles(1);
    flush_i = 1'b0;
    chk("mt_busy_hi", hi_o, sh_hi);
    chk("mt_busy_lo", lo_o, sh_lo);

    hi_we_i = 1'b1; wdata_i = 32'h1234_5678;
    idle_cycles(1);
    hi_we_i = 1'b0;
    chk("mthi_hi", hi_o, 32'h1234_5678);
    chk("mthi_lo", lo_o, sh_lo);
    lo_we_i = 1'b1; wdata_i = 32'hAABB_CCDD;
    idle_cycles(1);
    lo_we_i = 1'b0;
    chk("mtlo_lo", lo_o, 32'hAABB_CCDD);
    chk("mtlo_hi", hi_o, 32'h1234_5678);
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hCAFE_F00D;
    idle_cycles(1);
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    chk("mtboth_hi", hi_o, 32'hCAFE_F00D);
    chk("mtboth_lo", lo_o, 32'hCAFE_F00D);

    // MTHI on the same edge as an accepted start is dropped.
    op_i = 2'b01; a_i = 32'd4; b_i = 32'd4; start_i = 1'b1;
    hi_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    idle_cycles(1);
    start_i = 1'b0; hi_we_i = 1'b0;
    chk("start_busy", busy_o, 1);
    idle_cycles(3);
    flush_i = 1'b1;
    idle_cycles(1);
    flush_i = 1'b0;
    chk("mt_with_start_hi", hi_o, 32'hCAFE_F00D);

    // Flush beats start.
    op_i = 2'b00; a_i = 32'd1; b_i = 32'd1; start_i = 1'b1; flush_i = 1'b1;
    idle_cycles(1);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_beats_start", busy_o, 0);
    idle_cycles(1);

    // Randomised back-to-back operations against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = '0;
      else if (i % 3 == 1) rb = 32'($urandom_range(1, 9));
      else if (i % 4 == 2) rb = -32'($urandom_range(1, 9));
      if (i == 7) begin rop = 2'b10; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      start_op(rop, ra, rb, 1);
      wait_done(nb);
    end
    idle_cycles(2);

    // Asynchronous reset mid-operation.
    start_op(2'b00, 32'd123, 32'd456, 0);
    idle_cycles(10);
    rst_ni = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_hi", hi_o, 0);
    chk("midrst_lo", lo_o, 0);
    idle_cycles(1);
    rst_ni = 1'b1;
    repeat (45) @(negedge clk);
    chk("post_rst_hi", hi_o, 0);
    chk("post_rst_lo", lo_o, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
